// File: rtl/issue_queue_pkg.sv
// Shared control-word types for the issue queues plus small operand-readiness helpers.
package issue_queue_pkg;

  localparam int IQ_DEPTH = 8;
  localparam int IQ_NREGS = 32;

  typedef logic [$clog2(IQ_DEPTH+1)-1:0] iq_count_t;

  // Execution unit class carried by every control word.
  typedef enum logic [1:0] {
    EXU_ALU = 2'd0,
    EXU_MEM = 2'd1,
    EXU_BR  = 2'd2
  } exut;

  // Which queue instance an item is routed to.
  typedef enum logic {
    IQT_ALU = 1'b0,
    IQT_MEM = 1'b1
  } iqt;

  typedef struct packed {
    exut         exu_type;
    logic        shadowed;
    logic        has_rd;
    logic [4:0]  rd;
    logic        has_rs1;
    logic [4:0]  rs1;
    logic        has_rs2;
    logic [4:0]  rs2;
    logic [7:0]  op;
    logic [15:0] imm;
  } queue_item_t;

  // A source is ready when unused, x0, not pending, or being written back right now.
  function automatic logic src_ready(input logic [4:0]          idx,
                                     input logic                has,
                                     input logic [IQ_NREGS-1:0] busy_vec,
                                     input logic                wake_valid,
                                     input logic [4:0]          wake_rd);
    return !has || (idx == 5'd0) || !busy_vec[idx] || (wake_valid && (wake_rd == idx));
  endfunction

  // A destination with a pending write blocks issue to keep WAW order; wakeup is not enough.
  function automatic logic dst_ready(input logic [4:0]          idx,
                                     input logic                has,
                                     input logic [IQ_NREGS-1:0] busy_vec);
    return !has || (idx == 5'd0) || !busy_vec[idx];
  endfunction

endpackage

// File: rtl/issue_queue_if.sv
// Decode-side enqueue and register-read-side issue handshakes of one issue queue.
interface issue_queue_if;
  import issue_queue_pkg::*;

  logic        enq_valid;
  queue_item_t enq_item;
  logic        enq_ready;
  logic        iss_valid;
  queue_item_t iss_item;
  logic        iss_ready;

  // Environment side: decode pushes, register-read accepts.
  modport master (output enq_valid, enq_item, iss_ready,
                  input  enq_ready, iss_valid, iss_item);
  // Queue side.
  modport slave  (input  enq_valid, enq_item, iss_ready,
                  output enq_ready, iss_valid, iss_item);
endinterface

// File: rtl/iq_select.sv
// Lowest-index priority select over the eligibility vector; in-order mode only looks at slot 0.
module iq_select #(
  parameter int DEPTH    = 8,
  parameter int IN_ORDER = 1
) (
  input  logic [DEPTH-1:0]         elig,
  output logic [DEPTH-1:0]         grant,
  output logic [$clog2(DEPTH)-1:0] idx,
  output logic                     any
);
  localparam int IW = $clog2(DEPTH);

  // First eligible slot wins; slots above 0 are masked off in in-order mode.
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (elig[i] && !any && ((IN_ORDER == 0) || (i == 0))) begin
        grant[i] = 1'b1;
        idx      = IW'(i);
        any      = 1'b1;
      end
    end
  end
endmodule

// File: rtl/issue_queue.sv
// Compacting issue queue: slot 0 is oldest, one ready entry issues per cycle to register-read.
module issue_queue
  import issue_queue_pkg::*;
#(
  parameter int DEPTH    = IQ_DEPTH,
  parameter int IN_ORDER = 1,
  parameter int NREGS    = IQ_NREGS
) (
  input  logic                       clk,
  input  logic                       rst_n,
  issue_queue_if.slave               q,
  input  logic [NREGS-1:0]           busy_vec,
  input  logic                       wake_valid,
  input  logic [4:0]                 wake_rd,
  input  logic                       shadow_resolve,
  input  logic                       shadow_kill,
  input  logic                       flush,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int CW = $clog2(DEPTH+1);
  localparam int IW = $clog2(DEPTH);

  queue_item_t          item_q [DEPTH];
  queue_item_t          item_d [DEPTH];
  logic [DEPTH-1:0]     valid_q, valid_d;
  logic [CW-1:0]        count_q, count_d;

  logic [IQ_NREGS-1:0]  busy_ext;
  logic [DEPTH-1:0]     elig, grant;
  logic [IW-1:0]        sel_idx;
  logic                 sel_any;
  logic                 mem_seen;
  logic                 iss_fire, enq_fire;

  queue_item_t          stg_item [DEPTH];
  logic [DEPTH-1:0]     stg_vld, surv;
  logic                 passed;
  int                   wr, killed, rank, cnt_n;

  // Widen the scoreboard to the 32-entry form the readiness helpers expect.
  always_comb begin
    busy_ext = '0;
    busy_ext[NREGS-1:0] = busy_vec;
  end

  // Per-slot eligibility; a mem entry also waits for every older mem entry to leave.
  always_comb begin
    mem_seen = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      elig[i] = valid_q[i]
             && src_ready(item_q[i].rs1, item_q[i].has_rs1, busy_ext, wake_valid, wake_rd)
             && src_ready(item_q[i].rs2, item_q[i].has_rs2, busy_ext, wake_valid, wake_rd)
             && dst_ready(item_q[i].rd, item_q[i].has_rd, busy_ext)
             && !item_q[i].shadowed
             && !((item_q[i].exu_type == EXU_MEM) && mem_seen);
      if (valid_q[i] && (item_q[i].exu_type == EXU_MEM)) mem_seen = 1'b1;
    end
  end

  iq_select #(
    .DEPTH    (DEPTH),
    .IN_ORDER (IN_ORDER)
  ) u_select (
    .elig  (elig),
    .grant (grant),
    .idx   (sel_idx),
    .any   (sel_any)
  );

  // Credit comes from the registered count only; a dequeue never frees a slot in the same cycle.
  assign q.enq_ready = (int'(count_q) < DEPTH);
  assign q.iss_valid = sel_any && !flush;
  assign q.iss_item  = item_q[sel_idx];
  assign count       = count_q;
  assign iss_fire    = q.iss_valid && q.iss_ready;
  assign enq_fire    = q.enq_valid && q.enq_ready && !flush;

  // Next state: drop the issued slot, append the new item, apply shadow resolution, then flush.
  always_comb begin
    passed = 1'b0;
    for (int i = 0; i < DEPTH - 1; i++) begin
      passed = passed | grant[i];
      if (iss_fire && passed) begin
        stg_item[i] = item_q[i+1];
        stg_vld[i]  = valid_q[i+1];
      end else begin
        stg_item[i] = item_q[i];
        stg_vld[i]  = valid_q[i];
      end
    end
    stg_item[DEPTH-1] = item_q[DEPTH-1];
    stg_vld[DEPTH-1]  = valid_q[DEPTH-1] && !iss_fire;

    wr = int'(count_q) - (iss_fire ? 1 : 0);
    for (int i = 0; i < DEPTH; i++) begin
      if (enq_fire && (i == wr)) begin
        stg_item[i] = q.enq_item;
        stg_vld[i]  = 1'b1;
      end
    end

    for (int i = 0; i < DEPTH; i++) begin
      if (shadow_resolve && !shadow_kill) stg_item[i].shadowed = 1'b0;
    end

    killed = 0;
    for (int i = 0; i < DEPTH; i++) begin
      surv[i] = stg_vld[i] && !(shadow_resolve && shadow_kill && stg_item[i].shadowed);
      if (stg_vld[i] && !surv[i]) killed++;
    end

    // Slot o receives the o-th survivor, which keeps the age order of what remains.
    for (int o = 0; o < DEPTH; o++) begin
      item_d[o]  = stg_item[o];
      valid_d[o] = 1'b0;
      rank       = 0;
      for (int i = 0; i < DEPTH; i++) begin
        if (surv[i] && (rank == o)) begin
          item_d[o]  = stg_item[i];
          valid_d[o] = 1'b1;
        end
        if (surv[i]) rank++;
      end
    end

    cnt_n   = int'(count_q) + (enq_fire ? 1 : 0) - (iss_fire ? 1 : 0) - killed;
    count_d = CW'(cnt_n);

    if (flush) begin
      valid_d = '0;
      count_d = '0;
    end
  end

  // Entry storage and occupancy; reset clears contents so the idle issue item reads as zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) item_q[i] <= '0;
    end else begin
      count_q <= count_d;
      valid_q <= valid_d;
      item_q  <= item_d;
    end
  end

  count_in_range: assert property (@(posedge clk) disable iff (!rst_n) int'(count_q) <= DEPTH);

endmodule

// File: tb/tb_issue_queue.sv
// Directed bench: an out-of-order and an in-order queue share the scoreboard/control inputs.
module tb_issue_queue;
  import issue_queue_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] busy_vec;
  logic        wake_valid;
  logic [4:0]  wake_rd;
  logic        shadow_resolve, shadow_kill, flush;
  iq_count_t   count0, count1;
  int          n_checks = 0;
  int          n_fail = 0;

  issue_queue_if qif();
  issue_queue_if qif1();

  always #5 clk = ~clk;

  issue_queue #(.DEPTH(8), .IN_ORDER(0), .NREGS(32)) u_ooo (
    .clk(clk), .rst_n(rst_n), .q(qif), .busy_vec(busy_vec), .wake_valid(wake_valid),
    .wake_rd(wake_rd), .shadow_resolve(shadow_resolve), .shadow_kill(shadow_kill),
    .flush(flush), .count(count0));

  issue_queue #(.DEPTH(8), .IN_ORDER(1), .NREGS(32)) u_ino (
    .clk(clk), .rst_n(rst_n), .q(qif1), .busy_vec(busy_vec), .wake_valid(wake_valid),
    .wake_rd(wake_rd), .shadow_resolve(shadow_resolve), .shadow_kill(shadow_kill),
    .flush(flush), .count(count1));

  function automatic queue_item_t mk(input exut e, input logic sh,
                                     input logic hrd, input logic [4:0] rd,
                                     input logic hr1, input logic [4:0] r1,
                                     input logic hr2, input logic [4:0] r2,
                                     input logic [7:0] op);
    queue_item_t it;
    it.exu_type = e;   it.shadowed = sh;
    it.has_rd   = hrd; it.rd       = rd;
    it.has_rs1  = hr1; it.rs1      = r1;
    it.has_rs2  = hr2; it.rs2      = r2;
    it.op       = op;  it.imm      = {8'h5A, op};
    return it;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input queue_item_t it);
    qif.enq_valid = 1'b1;
    qif.enq_item  = it;
    tick();
    qif.enq_valid = 1'b0;
  endtask

  task automatic push1(input queue_item_t it);
    qif1.enq_valid = 1'b1;
    qif1.enq_item  = it;
    tick();
    qif1.enq_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (count0 !== 4'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", count0); end
    n_checks++; if (qif.enq_ready !== 1'b1) begin n_fail++; $display("FAIL reset_enq_ready: got %0b want 1", qif.enq_ready); end
    n_checks++; if (qif.iss_valid !== 1'b0) begin n_fail++; $display("FAIL reset_iss_valid: got %0b want 0", qif.iss_valid); end
    n_checks++; if (qif.iss_item !== '0) begin n_fail++; $display("FAIL reset_iss_item: got %h want 0", qif.iss_item); end
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    queue_item_t addi;
    addi = mk(EXU_ALU, 1'b0, 1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 8'h13);
    busy_vec = '0;
    qif.enq_valid = 1'b1;
    qif.enq_item  = addi;
    #1;
    n_checks++; if (qif.iss_valid !== 1'b0) begin n_fail++; $display("FAIL basic_no_bypass: iss_valid=%0b want 0", qif.iss_valid); end
    tick();
    qif.enq_valid = 1'b0;
    #1;
    n_checks++; if (count0 !== 4'd1) begin n_fail++; $display("FAIL basic_count1: got %0d want 1", count0); end
    n_checks++; if (qif.iss_valid !== 1'b1) begin n_fail++; $display("FAIL basic_iss_valid: got %0b want 1", qif.iss_valid); end
    n_checks++; if (qif.iss_item !== addi) begin n_fail++; $display("FAIL basic_iss_item: got %h want %h", qif.iss_item, addi); end
    qif.iss_ready = 1'b1;
    tick();
    n_checks++; if (count0 !== 4'd0) begin n_fail++; $display("FAIL basic_count0: got %0d want 0", count0); end
    n_checks++; if (qif.iss_valid !== 1'b0) begin n_fail++; $display("FAIL basic_drained: iss_valid=%0b want 0", qif.iss_valid); end
    qif.iss_ready = 1'b0;
  endtask

  task automatic test_out_of_order();
    queue_item_t a, b;
    a = mk(EXU_ALU, 1'b0, 1'b1, 5'd10, 1'b1, 5'd3, 1'b0, 5'd0, 8'h61);
    b = mk(EXU_ALU, 1'b0, 1'b1, 5'd11, 1'b1, 5'd4, 1'b0, 5'd0, 8'h62);
    busy_vec = 32'h1 << 3;
    push(a);
    push(b);
    #1;
    n_checks++; if (qif.iss_item !== b || qif.iss_valid !== 1'b1) begin n_fail++; $display("FAIL ooo_young_first: got v=%0b %h want v=1 %h", qif.iss_valid, qif.iss_item, b); end
    qif.iss_ready = 1'b1;
    tick();
    n_checks++; if (count0 !== 4'd1 || qif.iss_valid !== 1'b0) begin n_fail++; $display("FAIL ooo_blocked: count=%0d v=%0b want 1/0", count0, qif.iss_valid); end
    wake_valid = 1'b1;
    wake_rd    = 5'd3;
    #1;
    n_checks++; if (qif.iss_item !== a || qif.iss_valid !== 1'b1) begin n_fail++; $display("FAIL ooo_wake_issue: got v=%0b %h want v=1 %h", qif.iss_valid, qif.iss_item, a); end
    tick();
    wake_valid = 1'b0;
    busy_vec   = '0;
    n_checks++; if (count0 !== 4'd0) begin n_fail++; $display("FAIL ooo_drained: count=%0d want 0", count0); end
    qif.iss_ready = 1'b0;
  endtask

  task automatic test_in_order();
    queue_item_t a, b;
    a = mk(EXU_ALU, 1'b0, 1'b1, 5'd10, 1'b1, 5'd3, 1'b0, 5'd0, 8'h71);
    b = mk(EXU_ALU, 1'b0, 1'b1, 5'd11, 1'b1, 5'd4, 1'b0, 5'd0, 8'h72);
    busy_vec = 32'h1 << 3;
    push1(a);
    push1(b);
    #1;
    n_checks++; if (count1 !== 4'd2 || qif1.iss_valid !== 1'b0) begin n_fail++; $display("FAIL ino_head_blocks: count=%0d v=%0b want 2/0", count1, qif1.iss_valid); end
    wake_valid = 1'b1;
    wake_rd    = 5'd3;
    #1;
    n_checks++; if (qif1.iss_item !== a || qif1.iss_valid !== 1'b1) begin n_fail++; $display("FAIL ino_head_issue: got v=%0b %h want v=1 %h", qif1.iss_valid, qif1.iss_item, a); end
    qif1.iss_ready = 1'b1;
    tick();
    wake_valid = 1'b0;
    busy_vec   = '0;
    #1;
    n_checks++; if (qif1.iss_item !== b || qif1.iss_valid !== 1'b1) begin n_fail++; $display("FAIL ino_second: got v=%0b %h want v=1 %h", qif1.iss_valid, qif1.iss_item, b); end
    tick();
    n_checks++; if (count1 !== 4'd0) begin n_fail++; $display("FAIL ino_drained: count=%0d want 0", count1); end
    qif1.iss_ready = 1'b0;
  endtask

  task automatic test_mem_order();
    queue_item_t lw, sw;
    lw = mk(EXU_MEM, 1'b0, 1'b1, 5'd7, 1'b1, 5'd6, 1'b0, 5'd0, 8'h03);
    sw = mk(EXU_MEM, 1'b0, 1'b0, 5'd0, 1'b1, 5'd8, 1'b1, 5'd9, 8'h23);
    busy_vec = 32'h1 << 6;
    push(lw);
    push(sw);
    #1;
    n_checks++; if (count0 !== 4'd2 || qif.iss_valid !== 1'b0) begin n_fail++; $display("FAIL mem_store_held: count=%0d v=%0b want 2/0", count0, qif.iss_valid); end
    busy_vec = '0;
    #1;
    n_checks++; if (qif.iss_item !== lw || qif.iss_valid !== 1'b1) begin n_fail++; $display("FAIL mem_load_first: got v=%0b %h want v=1 %h", qif.iss_valid, qif.iss_item, lw); end
    qif.iss_ready = 1'b1;
    tick();
    n_checks++; if (qif.iss_item !== sw || qif.iss_valid !== 1'b1) begin n_fail++; $display("FAIL mem_store_next: got v=%0b %h want v=1 %h", qif.iss_valid, qif.iss_item, sw); end
    tick();
    n_checks++; if (count0 !== 4'd0) begin n_fail++; $display("FAIL mem_drained: count=%0d want 0", count0); end
    qif.iss_ready = 1'b0;
  endtask

  task automatic test_fill();
    for (int i = 0; i < 8; i++) push(mk(EXU_ALU, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 8'h20 + 8'(i)));
    #1;
    n_checks++; if (count0 !== 4'd8) begin n_fail++; $display("FAIL fill_count: got %0d want 8", count0); end
    n_checks++; if (qif.enq_ready !== 1'b0) begin n_fail++; $display("FAIL fill_enq_ready: got %0b want 0", qif.enq_ready); end
    qif.iss_ready = 1'b1;
    qif.enq_valid = 1'b1;
    qif.enq_item  = mk(EXU_ALU, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 8'hAA);
    #1;
    n_checks++; if (qif.iss_item.op !== 8'h20) begin n_fail++; $display("FAIL full_oldest: op=%h want 20", qif.iss_item.op); end
    tick();
    qif.enq_valid = 1'b0;
    n_checks++; if (count0 !== 4'd7) begin n_fail++; $display("FAIL full_issue_no_enq: count=%0d want 7", count0); end
    for (int k = 0; k < 7; k++) begin
      n_checks++; if (qif.iss_item.op !== 8'h21 + 8'(k) || qif.iss_valid !== 1'b1) begin n_fail++; $display("FAIL drain_order_%0d: v=%0b op=%h want 1/%h", k, qif.iss_valid, qif.iss_item.op, 8'h21 + 8'(k)); end
      tick();
    end
    n_checks++; if (count0 !== 4'd0) begin n_fail++; $display("FAIL fill_drained: count=%0d want 0", count0); end
    qif.iss_ready = 1'b0;
  endtask

  task automatic test_shadow_kill();
    queue_item_t s1, n1, s2, n2, s3, s4;
    s1 = mk(EXU_ALU, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 8'h40);
    n1 = mk(EXU_ALU, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 8'h41);
    s2 = mk(EXU_ALU, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 8'h42);
    n2 = mk(EXU_ALU, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 8'h43);
    s3 = mk(EXU_ALU, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 8'h44);
    s4 = mk(EXU_ALU, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 8'h45);
    push(s1); push(n1); push(s2); push(n2); push(s3);
    #1;
    n_checks++; if (count0 !== 4'd5 || qif.iss_item !== n1) begin n_fail++; $display("FAIL kill_pre: count=%0d item=%h want 5/%h", count0, qif.iss_item, n1); end
    shadow_resolve = 1'b1;
    shadow_kill    = 1'b1;
    qif.enq_valid  = 1'b1;
    qif.enq_item   = s4;
    tick();
    shadow_resolve = 1'b0;
    shadow_kill    = 1'b0;
    qif.enq_valid  = 1'b0;
    #1;
    n_checks++; if (count0 !== 4'd2) begin n_fail++; $display("FAIL kill_count: got %0d want 2", count0); end
    n_checks++; if (qif.iss_item !== n1 || qif.iss_valid !== 1'b1) begin n_fail++; $display("FAIL kill_survivor0: v=%0b %h want 1/%h", qif.iss_valid, qif.iss_item, n1); end
    qif.iss_ready = 1'b1;
    tick();
    n_checks++; if (qif.iss_item !== n2 || qif.iss_valid !== 1'b1) begin n_fail++; $display("FAIL kill_survivor1: v=%0b %h want 1/%h", qif.iss_valid, qif.iss_item, n2); end
    tick();
    n_checks++; if (count0 !== 4'd0) begin n_fail++; $display("FAIL kill_drained: count=%0d want 0", count0); end
    qif.iss_ready = 1'b0;
  endtask

  task automatic test_shadow_release();
    queue_item_t seq [5];
    queue_item_t exp_seq [5];
    for (int i = 0; i < 5; i++) begin
      seq[i] = mk(EXU_ALU, (i % 2 == 0), 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 8'h80 + 8'(i));
      exp_seq[i] = seq[i];
      exp_seq[i].shadowed = 1'b0;
      push(seq[i]);
    end
    shadow_resolve = 1'b1;
    shadow_kill    = 1'b0;
    #1;
    n_checks++; if (qif.iss_item !== seq[1]) begin n_fail++; $display("FAIL release_same_cycle: got %h want %h", qif.iss_item, seq[1]); end
    tick();
    shadow_resolve = 1'b0;
    #1;
    n_checks++; if (count0 !== 4'd5) begin n_fail++; $display("FAIL release_count: got %0d want 5", count0); end
    qif.iss_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      n_checks++; if (qif.iss_item !== exp_seq[k] || qif.iss_valid !== 1'b1) begin n_fail++; $display("FAIL release_order_%0d: v=%0b %h want 1/%h", k, qif.iss_valid, qif.iss_item, exp_seq[k]); end
      tick();
    end
    n_checks++; if (count0 !== 4'd0) begin n_fail++; $display("FAIL release_drained: count=%0d want 0", count0); end
    qif.iss_ready = 1'b0;
  endtask

  task automatic test_flush();
    for (int i = 0; i < 5; i++) push(mk(EXU_ALU, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 8'h50 + 8'(i)));
    #1;
    n_checks++; if (count0 !== 4'd5) begin n_fail++; $display("FAIL flush_pre_count: got %0d want 5", count0); end
    flush          = 1'b1;
    qif.iss_ready  = 1'b1;
    qif.enq_valid  = 1'b1;
    qif.enq_item   = mk(EXU_ALU, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 8'h5F);
    #1;
    n_checks++; if (qif.iss_valid !== 1'b0) begin n_fail++; $display("FAIL flush_iss_valid: got %0b want 0", qif.iss_valid); end
    tick();
    flush         = 1'b0;
    qif.enq_valid = 1'b0;
    #1;
    n_checks++; if (count0 !== 4'd0 || qif.iss_valid !== 1'b0) begin n_fail++; $display("FAIL flush_empty: count=%0d v=%0b want 0/0", count0, qif.iss_valid); end
    tick();
    n_checks++; if (count0 !== 4'd0) begin n_fail++; $display("FAIL flush_enq_dropped: count=%0d want 0", count0); end
    qif.iss_ready = 1'b0;
  endtask

  task automatic test_async_reset();
    push(mk(EXU_ALU, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 8'h99));
    qif.iss_ready = 1'b1;
    #1;
    n_checks++; if (qif.iss_valid !== 1'b1) begin n_fail++; $display("FAIL arst_pre: iss_valid=%0b want 1", qif.iss_valid); end
    rst_n = 1'b0;
    #1;
    n_checks++; if (qif.iss_valid !== 1'b0 || count0 !== 4'd0) begin n_fail++; $display("FAIL arst_immediate: v=%0b count=%0d want 0/0", qif.iss_valid, count0); end
    n_checks++; if (qif.enq_ready !== 1'b1) begin n_fail++; $display("FAIL arst_enq_ready: got %0b want 1", qif.enq_ready); end
    #1;
    rst_n = 1'b1;
    qif.iss_ready = 1'b0;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    busy_vec = '0; wake_valid = 1'b0; wake_rd = 5'd0;
    shadow_resolve = 1'b0; shadow_kill = 1'b0; flush = 1'b0;
    qif.enq_valid = 1'b0;  qif.enq_item = '0;  qif.iss_ready = 1'b0;
    qif1.enq_valid = 1'b0; qif1.enq_item = '0; qif1.iss_ready = 1'b0;
    test_reset();
    test_basic();
    test_out_of_order();
    test_in_order();
    test_mem_order();
    test_fill();
    test_shadow_kill();
    test_shadow_release();
    test_flush();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
